// File: rtl/mul_issue_ctrl_pkg.sv
// Shared opcodes, datapath width and result correction for the multiplier
// issue/writeback wrapper.
package mul_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULH   = 2'd1;
    localparam logic [1:0] OP_MULHSU = 2'd2;
    localparam logic [1:0] OP_MULHU  = 2'd3;

    // The core produces a signed*signed product; unsigned high words are
    // recovered by adding back the operand whose partner had its MSB set.
    function automatic logic [XLEN-1:0] mul_fix(
        input logic [1:0]        op,
        input logic [2*XLEN-1:0] dst,
        input logic [XLEN-1:0]   a,
        input logic [XLEN-1:0]   b
    );
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] add_a;
        logic [XLEN-1:0] add_b;
        logic [XLEN-1:0] res;
        hi    = dst[2*XLEN-1:XLEN];
        add_a = b[XLEN-1] ? a : {XLEN{1'b0}};
        add_b = a[XLEN-1] ? b : {XLEN{1'b0}};
        case (op)
            OP_MUL:    res = dst[XLEN-1:0];
            OP_MULH:   res = hi;
            OP_MULHSU: res = hi + add_a;
            OP_MULHU:  res = hi + add_a + add_b;
            default:   res = dst[XLEN-1:0];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_fifo.sv
// Result FIFO with a registered show-ahead head, plus its overflow checker.
// count includes the head register, so it is the number of results held.
module mul_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_mem_cnt;
    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_data;
    logic             w_pop_ok;
    logic             w_fetch;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
    endfunction

    assign w_pop_ok = pop & r_out_vld;
    // Refill the head register whenever it is empty or being consumed.
    assign w_fetch  = (r_mem_cnt != CW'(0)) & (~r_out_vld | w_pop_ok);

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_mem_cnt  <= {CW{1'b0}};
            r_out_vld  <= 1'b0;
            r_out_data <= {WIDTH{1'b0}};
        end else begin
            if (push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_fetch) begin
                r_rd_ptr   <= ptr_inc(r_rd_ptr);
                r_out_vld  <= 1'b1;
                r_out_data <= r_mem[r_rd_ptr];
            end else if (w_pop_ok) begin
                r_out_vld  <= 1'b0;
            end
            r_mem_cnt <= r_mem_cnt + CW'(push) - CW'(w_fetch);
        end
    end

    assign dout       = r_out_data;
    assign dout_valid = r_out_vld;
    assign count      = r_mem_cnt + CW'(r_out_vld);
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == CW'(0));

endmodule

module mul_res_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic full
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback wrapper for a fixed-latency signed multiplier core: credit-based
// admission, in-flight tracking, unsigned high-word correction and a result FIFO.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int MUL_LAT    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [XLEN-1:0]   mul_op1,
    output logic [XLEN-1:0]   mul_op2,
    input  logic [2*XLEN-1:0] mul_dst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int NST = MUL_LAT + 1;
    localparam int FW  = XLEN + TAG_W;
    localparam int CW  = $clog2(NST + FIFO_DEPTH + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    logic [NST-1:0]   r_vld;
    logic [1:0]       r_op  [NST];
    logic [TAG_W-1:0] r_tag [NST];
    logic [XLEN-1:0]  r_a   [NST];
    logic [XLEN-1:0]  r_b   [NST];
    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;

    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_fifo_vld;
    logic [FW-1:0]    w_push_data;
    logic [FW-1:0]    w_head;
    logic [FCW-1:0]   w_fifo_cnt;
    logic [CW-1:0]    w_stage_cnt;
    logic [CW-1:0]    w_inflight;

    // Count occupied tracking stages.
    always_comb begin
        w_stage_cnt = {CW{1'b0}};
        for (int i = 0; i < NST; i++) begin
            w_stage_cnt = w_stage_cnt + CW'(r_vld[i]);
        end
    end

    // Every accepted op owns a FIFO slot until popped, so the core never overruns it.
    assign w_inflight = w_stage_cnt + CW'(w_fifo_cnt);
    assign in_ready   = (w_inflight < CW'(FIFO_DEPTH));
    assign w_accept   = in_valid & in_ready;

    // Operand registers feeding the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1 <= {XLEN{1'b0}};
            r_op2 <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_op1 <= in_a;
            r_op2 <= in_b;
        end
    end

    // Tracking shift register: tail lines up with the core's dst for that op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= {NST{1'b0}};
            for (int i = 0; i < NST; i++) begin
                r_op[i]  <= 2'd0;
                r_tag[i] <= {TAG_W{1'b0}};
                r_a[i]   <= {XLEN{1'b0}};
                r_b[i]   <= {XLEN{1'b0}};
            end
        end else begin
            r_vld <= {r_vld[NST-2:0], w_accept};
            if (w_accept) begin
                r_op[0]  <= in_op;
                r_tag[0] <= in_tag;
                r_a[0]   <= in_a;
                r_b[0]   <= in_b;
            end
            for (int i = 1; i < NST; i++) begin
                r_op[i]  <= r_op[i-1];
                r_tag[i] <= r_tag[i-1];
                r_a[i]   <= r_a[i-1];
                r_b[i]   <= r_b[i-1];
            end
        end
    end

    assign w_push      = r_vld[NST-1];
    assign w_push_data = {r_tag[NST-1],
                          mul_fix(r_op[NST-1], mul_dst, r_a[NST-1], r_b[NST-1])};
    assign w_pop       = out_ready & w_fifo_vld;

    mul_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .din        (w_push_data),
        .pop        (w_pop),
        .dout       (w_head),
        .dout_valid (w_fifo_vld),
        .full       (w_full),
        .empty      (w_empty),
        .count      (w_fifo_cnt)
    );

    mul_res_fifo_chk u_fifo_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .full  (w_full)
    );

    assign mul_op1   = r_op1;
    assign mul_op2   = r_op2;
    assign out_valid = w_fifo_vld;
    assign out_data  = w_head[XLEN-1:0];
    assign out_tag   = w_head[FW-1:XLEN];
    assign busy      = (|r_vld) | ~w_empty;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with a behavioural 3-stage signed
// multiplier core and a scoreboard of expected {tag, data} results.
module tb_mul_issue_ctrl;
    import mul_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_tag;
    logic [31:0] mul_op1;
    logic [31:0] mul_op2;
    logic [63:0] mul_dst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        busy;

    logic [63:0] core_p0;
    logic [63:0] core_p1;
    logic [35:0] sb_q [$];
    logic [35:0] mon_exp;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops   = 0;

    mul_issue_ctrl #(
        .MUL_LAT    (3),
        .FIFO_DEPTH (4),
        .TAG_W      (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .mul_op1   (mul_op1),
        .mul_op2   (mul_op2),
        .mul_dst   (mul_dst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural core: samples op1/op2, dst valid three edges later, no reset.
    always @(posedge clk) begin
        core_p0 <= {{32{mul_op1[31]}}, mul_op1} * {{32{mul_op2[31]}}, mul_op2};
        core_p1 <= core_p0;
        mul_dst <= core_p1;
    end

    // Scoreboard: every pop must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            n_pops++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: got tag=%h data=%h, required no output", out_tag, out_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({out_tag, out_data} !== mon_exp) begin
                    n_errors++;
                    $display("FAIL sb_result: got tag=%h data=%h, required tag=%h data=%h",
                             out_tag, out_data, mon_exp[35:32], mon_exp[31:0]);
                end
            end
        end
    end

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'd0:    p = sa * sb;
            2'd1:    p = sa * sb;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] exp);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!in_ready) begin
            n_errors++;
            $display("FAIL issue_timeout: in_ready=%0b, required 1 within 100 cycles", in_ready);
            in_valid = 1'b0;
        end else begin
            sb_q.push_back({tag, exp});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int c;
        c         = 0;
        out_ready = 1'b1;
        while ((sb_q.size() != 0 || busy) && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_checks++;
        if (sb_q.size() != 0 || busy) begin
            n_errors++;
            $display("FAIL drain: pending=%0d busy=%0b, required 0 and 0", sb_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_tag    = 4'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 4;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        if (out_data !== 32'd0 || out_tag !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_out: data=%h tag=%h, required 0 0", out_data, out_tag);
        end
        if (mul_op1 !== 32'd0 || mul_op2 !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_ops: op1=%h op2=%h, required 0 0", mul_op1, mul_op2);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int n;
        out_ready = 1'b1;
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 4'd1, 32'hFFFF_FFEB);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL latency_busy: got %b, required 1", busy);
        end
        n = 0;
        while (!out_valid && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n != 5) begin
            n_errors++;
            $display("FAIL latency: out_valid after %0d edges, required 5", n);
        end
        drain();
    endtask

    task automatic test_ops();
        issue(OP_MULH,   32'h8000_0000, 32'h8000_0000, 4'd2, 32'h4000_0000);
        issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'hFFFF_FFFF);
        issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 32'hFFFF_FFFE);
        issue(OP_MULHU,  32'h8000_0000, 32'h0000_0002, 4'd5, 32'h0000_0001);
        issue(OP_MUL,    32'h8000_0000, 32'hFFFF_FFFF, 4'd6, 32'h8000_0000);
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            issue(OP_MUL, 32'(i), 32'(i), 4'(i - 1), 32'(i * i));
        end
        drain();
    endtask

    task automatic test_backpressure();
        int idx;
        int pops0;
        logic [31:0] held;
        pops0     = n_pops;
        idx       = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_MUL;
        in_a      = 32'd10;
        in_b      = 32'd3;
        in_tag    = 4'd8;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == 20) begin
                n_checks += 3;
                if (idx != 4 || in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 4 0", idx, in_ready);
                end
                if (out_valid !== 1'b1 || out_data !== sb_q[0][31:0]) begin
                    n_errors++;
                    $display("FAIL bp_head: valid=%b data=%h, required 1 %h", out_valid, out_data, sb_q[0][31:0]);
                end
                held = out_data;
                repeat (3) @(negedge clk);
                if (out_data !== held || out_tag !== sb_q[0][35:32]) begin
                    n_errors++;
                    $display("FAIL bp_hold: data=%h tag=%h, required %h %h", out_data, out_tag, held, sb_q[0][35:32]);
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({4'(idx + 8), 32'((idx + 10) * 3)});
                idx++;
            end
            @(posedge clk);
            #1;
            if (c == 20) begin
                out_ready = 1'b1;
            end
            in_valid = (idx < 8);
            in_a     = 32'(idx + 10);
            in_tag   = 4'(idx + 8);
        end
        in_valid = 1'b0;
        drain();
        n_checks++;
        if (idx != 8 || n_pops - pops0 != 8) begin
            n_errors++;
            $display("FAIL bp_total: accepted=%0d popped=%0d, required 8 8", idx, n_pops - pops0);
        end
    endtask

    task automatic test_reset_midop();
        logic seen;
        out_ready = 1'b1;
        issue(OP_MUL,   32'd5,         32'd6,         4'd2, 32'd30);
        issue(OP_MULH,  32'h1234_5678, 32'h9ABC_DEF0, 4'd3, ref_res(OP_MULH, 32'h1234_5678, 32'h9ABC_DEF0));
        issue(OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'd4, ref_res(OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D));
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midop_reset: out_valid=%b busy=%b in_ready=%b, required 0 0 1", out_valid, busy, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid | busy;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++;
            $display("FAIL midop_stale: out_valid/busy seen=%b, required 0", seen);
        end
        issue(OP_MULHU, 32'h8000_0000, 32'h0000_0002, 4'd9, 32'h0000_0001);
        drain();
    endtask

    task automatic test_random();
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [1:0]  op;
                    logic [31:0] a;
                    logic [31:0] b;
                    op = 2'($urandom_range(0, 3));
                    a  = (i % 5 == 0) ? 32'h8000_0000 : 32'($urandom);
                    b  = (i % 7 == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                    issue(op, a, b, 4'(i), ref_res(op, a, b));
                end
            end
            begin
                repeat (150) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
